pic_inta_sequencer: RTL and testbench
=====================================

// Module: pic_inta_sequencer
// PURPOSE
//  Consumer side of the 8259 priority resolver. Takes its INTFLAG/PriorityID, raises INT to the
//  CPU and runs the 8086-mode two-pulse INTA handshake. It owns the In-Service Register and
//  last_serviced, which feed back to the resolver. It also handles specific/non-specific/auto EOI.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max clk cycles waiting for 2nd INTA before aborting (8-bit counter)
// PORTS
//  clk             in   1  system clock; all logic on rising edge
//  reset           in   1  synchronous, active-high reset
//  int_flag        in   1  resolver INTFLAG: a request has won
//  priority_id     in   3  resolver PriorityID
//  inta_n          in   1  CPU interrupt acknowledge, active low, synchronous to clk
//  icw2_base       in   5  ICW2 T7..T3, vector base
//  auto_eoi        in   1  ICW4 AEOI mode
//  rotating_mode   in   1  1 = rotating priority, 0 = fully nested
//  rotate_on_eoi   in   1  EOI or AEOI updates last_serviced
//  eoi_nonspec     in   1  1-cycle strobe: non-specific EOI (OCW2)
//  eoi_spec        in   1  1-cycle strobe: specific EOI (OCW2)
//  eoi_level       in   3  level for specific EOI
//  int_out         out  1  INT to CPU
//  isr             out  8  In-Service Register (to resolver IS_status)
//  last_serviced   out  3  lowest-priority pointer (to resolver)
//  ir_ack          out  8  one-hot 1-cycle pulse telling IRR to clear the acknowledged request
//  data_out        out  8  vector byte
//  data_oe         out  1  data bus drive enable
//  ack_busy        out  1  high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; int_out=0, isr=0, last_serviced=3'b111 (IR0 highest), ir_ack=0,
//   data_out=0, data_oe=0, ack_busy=0, timeout counter=0. Reset wins mid-handshake.
//  inta_q: inta_n registered. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
//  FSM:
//   IDLE  : int_flag=1 -> REQ. int_out rises on that edge (1-cycle latency).
//   REQ   : int_out=1. int_flag=0 before fall -> IDLE, int_out=0. fall -> ACK1.
//   ACK1 entry (on fall): int_out=0; cap_id<=priority_id if int_flag=1, else 3'd7 (spurious).
//           Non-spurious: isr[cap_id]<=1 and ir_ack=onehot(cap_id) for exactly 1 cycle.
//           Spurious: isr and ir_ack unchanged. No data driven. rise -> WAIT2, counter cleared.
//   WAIT2 : counter increments each cycle. fall -> ACK2.
//           Counter==TIMEOUT_CYCLES -> IDLE (abort); isr bit stays set.
//   ACK2  : data_out={icw2_base,cap_id}, data_oe=1 every cycle inta_n is low.
//           rise -> data_oe=0, IDLE. If auto_eoi and not spurious: isr[cap_id]<=0 on that edge.
//           With auto_eoi and rotate_on_eoi, last_serviced<=cap_id on that edge.
//  EOI (honoured in any state):
//   eoi_spec: clear isr[eoi_level]; if rotate_on_eoi, last_serviced<=eoi_level.
//   eoi_nonspec: clear highest-priority set isr bit.
//    Fully nested: lowest index. Rotating: first set bit scanning last_serviced+1 upward, mod 8.
//    If rotate_on_eoi, last_serviced<=cleared index. isr==0 -> no change.
//   Both strobes in one cycle: specific takes precedence; non-specific ignored.
//  Simultaneous set (ACK1 entry) and clear (EOI/AEOI) of the same bit: set wins.
//   Distinct bits: both apply.
//  A fall in IDLE/ACK1/ACK2 or a rise in REQ/WAIT2 is ignored. No state change on stray edges.
// TESTING
//  1 base=5'h08, int_flag=1, id=3, auto_eoi=0 -> int_out=1 next cycle.
//    1st INTA fall -> isr=8'h08, ir_ack=8'h08 for 1 cycle. 2nd INTA low -> data_out=8'h43, data_oe=1.
//  2 As 1 with auto_eoi=1, rotate_on_eoi=1 -> isr=8'h00 after 2nd rise; last_serviced=3.
//  3 int_flag falls between REQ and 1st INTA fall -> isr unchanged, ir_ack=0, 2nd INTA data_out=8'h47.
//  4 isr=8'b00100100, eoi_nonspec:
//    rotating_mode=0 -> isr=8'b00100000.
//    rotating_mode=1, last_serviced=4 -> isr=8'b00000100; last_serviced=5 if rotate_on_eoi.
//  5 After 1st INTA, hold inta_n high TIMEOUT_CYCLES+1 cycles -> ack_busy=0, state IDLE, isr bit held.
//  6 reset asserted during ACK2 -> next edge all outputs at reset values, data_oe=0.

Source files
------------

// File: rtl/pic_inta_sequencer.sv
// 8259 INTA sequencer: drives INT, runs the 8086 two-pulse acknowledge, owns the ISR
// and last_serviced, and applies specific / non-specific / automatic EOI.
module pic_inta_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_flag,
    input  logic [2:0] priority_id,
    input  logic       inta_n,
    input  logic [4:0] icw2_base,
    input  logic       auto_eoi,
    input  logic       rotating_mode,
    input  logic       rotate_on_eoi,
    input  logic       eoi_nonspec,
    input  logic       eoi_spec,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [2:0] last_serviced,
    output logic [7:0] ir_ack,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       ack_busy
);
    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t     state_q, state_d;
    logic       inta_q;
    logic       int_out_q, int_out_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] last_q, last_d;
    logic [7:0] ir_ack_q, ir_ack_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] cap_id_q, cap_id_d;
    logic       spur_q, spur_d;
    logic       fall, rise;
    logic       ns_found;
    logic [2:0] ns_idx;

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;

    // Highest-priority in-service level for a non-specific EOI.
    always_comb begin
        logic [2:0] k;
        ns_found = 1'b0;
        ns_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            k = rotating_mode ? (last_q + 3'(i) + 3'd1) : 3'(i);
            if (!ns_found && isr_q[k]) begin
                ns_found = 1'b1;
                ns_idx   = k;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        int_out_d  = int_out_q;
        isr_d      = isr_q;
        last_d     = last_q;
        ir_ack_d   = 8'h00;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        cnt_d      = cnt_q;
        cap_id_d   = cap_id_q;
        spur_d     = spur_q;

        // Clears first so that a same-cycle ACK1 set of the same bit wins.
        if (state_q == ACK2 && rise && auto_eoi && !spur_q) begin
            isr_d[cap_id_q] = 1'b0;
            if (rotate_on_eoi) last_d = cap_id_q;
        end
        if (eoi_spec) begin
            isr_d[eoi_level] = 1'b0;
            if (rotate_on_eoi) last_d = eoi_level;
        end else if (eoi_nonspec && ns_found) begin
            isr_d[ns_idx] = 1'b0;
            if (rotate_on_eoi) last_d = ns_idx;
        end

        case (state_q)
            IDLE: if (int_flag) begin
                state_d   = REQ;
                int_out_d = 1'b1;
            end
            REQ: begin
                if (fall) begin
                    state_d   = ACK1;
                    int_out_d = 1'b0;
                    spur_d    = ~int_flag;
                    cap_id_d  = int_flag ? priority_id : 3'd7;
                    if (int_flag) begin
                        isr_d[priority_id]    = 1'b1;
                        ir_ack_d[priority_id] = 1'b1;
                    end
                end else if (!int_flag) begin
                    state_d   = IDLE;
                    int_out_d = 1'b0;
                end
            end
            ACK1: if (rise) begin
                state_d = WAIT2;
                cnt_d   = 8'd0;
            end
            WAIT2: begin
                if (fall) begin
                    state_d    = ACK2;
                    data_out_d = {icw2_base, cap_id_q};
                    data_oe_d  = 1'b1;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d   = IDLE;
                    data_oe_d = 1'b0;
                end else begin
                    data_out_d = {icw2_base, cap_id_q};
                    data_oe_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            inta_q     <= 1'b1;
            int_out_q  <= 1'b0;
            isr_q      <= 8'h00;
            last_q     <= 3'b111;
            ir_ack_q   <= 8'h00;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            cnt_q      <= 8'd0;
            cap_id_q   <= 3'd0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inta_q     <= inta_n;
            int_out_q  <= int_out_d;
            isr_q      <= isr_d;
            last_q     <= last_d;
            ir_ack_q   <= ir_ack_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            cnt_q      <= cnt_d;
            cap_id_q   <= cap_id_d;
            spur_q     <= spur_d;
        end
    end

    assign int_out       = int_out_q;
    assign isr           = isr_q;
    assign last_serviced = last_q;
    assign ir_ack        = ir_ack_q;
    assign data_out      = data_out_q;
    assign data_oe       = data_oe_q;
    assign ack_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: handshakes, AEOI, spurious, EOI variants,
// second-INTA timeout and reset during ACK2.
module tb_pic_inta_sequencer;
    logic       clk = 1'b0;
    logic       reset, int_flag, inta_n, auto_eoi, rotating_mode, rotate_on_eoi;
    logic       eoi_nonspec, eoi_spec;
    logic [2:0] priority_id, eoi_level;
    logic [4:0] icw2_base;
    logic       int_out, data_oe, ack_busy;
    logic [7:0] isr, ir_ack, data_out;
    logic [2:0] last_serviced;

    int n_cmp = 0;
    int n_err = 0;

    pic_inta_sequencer #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .int_flag(int_flag), .priority_id(priority_id),
        .inta_n(inta_n), .icw2_base(icw2_base), .auto_eoi(auto_eoi),
        .rotating_mode(rotating_mode), .rotate_on_eoi(rotate_on_eoi),
        .eoi_nonspec(eoi_nonspec), .eoi_spec(eoi_spec), .eoi_level(eoi_level),
        .int_out(int_out), .isr(isr), .last_serviced(last_serviced), .ir_ack(ir_ack),
        .data_out(data_out), .data_oe(data_oe), .ack_busy(ack_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full handshake for level id; checks the vector byte on the second INTA.
    task automatic handshake(input logic [2:0] id, input logic [7:0] exp_vec);
        int_flag = 1'b1; priority_id = id; tick();
        inta_n = 1'b0; tick();
        int_flag = 1'b0;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("hs_vec", {24'd0, data_out}, {24'd0, exp_vec});
        inta_n = 1'b1; tick();
    endtask

    task automatic pulse_spec(input logic [2:0] lvl);
        eoi_spec = 1'b1; eoi_level = lvl; tick();
        eoi_spec = 1'b0;
    endtask

    initial begin
        reset = 1'b1; int_flag = 0; inta_n = 1; auto_eoi = 0; rotating_mode = 0;
        rotate_on_eoi = 0; eoi_nonspec = 0; eoi_spec = 0; priority_id = 0; eoi_level = 0;
        icw2_base = 5'h08;
        tick(); tick();
        chk("rst_int", {31'd0, int_out}, 0);
        chk("rst_isr", {24'd0, isr}, 0);
        chk("rst_last", {29'd0, last_serviced}, 7);
        chk("rst_ack", {24'd0, ir_ack}, 0);
        chk("rst_oe", {31'd0, data_oe}, 0);
        chk("rst_busy", {31'd0, ack_busy}, 0);
        reset = 1'b0; tick();

        // 1: basic handshake, id 3
        int_flag = 1'b1; priority_id = 3'd3; tick();
        chk("t1_int", {31'd0, int_out}, 1);
        chk("t1_busy", {31'd0, ack_busy}, 1);
        inta_n = 1'b0; tick();
        chk("t1_isr", {24'd0, isr}, 8'h08);
        chk("t1_irack", {24'd0, ir_ack}, 8'h08);
        chk("t1_intlo", {31'd0, int_out}, 0);
        chk("t1_oe_ack1", {31'd0, data_oe}, 0);
        tick();
        chk("t1_irack_pulse", {24'd0, ir_ack}, 0);
        int_flag = 1'b0; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t1_data", {24'd0, data_out}, 8'h43);
        chk("t1_oe", {31'd0, data_oe}, 1);
        tick();
        chk("t1_oe_hold", {31'd0, data_oe}, 1);
        inta_n = 1'b1; tick();
        chk("t1_oe_off", {31'd0, data_oe}, 0);
        chk("t1_idle", {31'd0, ack_busy}, 0);
        chk("t1_isr_kept", {24'd0, isr}, 8'h08);
        pulse_spec(3'd3);
        chk("t1_spec", {24'd0, isr}, 0);
        chk("t1_last", {29'd0, last_serviced}, 7);

        // 2: AEOI with rotation
        auto_eoi = 1'b1; rotate_on_eoi = 1'b1;
        handshake(3'd3, 8'h43);
        chk("t2_isr", {24'd0, isr}, 0);
        chk("t2_last", {29'd0, last_serviced}, 3);
        auto_eoi = 1'b0; rotate_on_eoi = 1'b0;

        // 3: int_flag drops on the first INTA fall -> spurious level 7
        int_flag = 1'b1; priority_id = 3'd2; tick();
        int_flag = 1'b0; inta_n = 1'b0; tick();
        chk("t3_isr", {24'd0, isr}, 0);
        chk("t3_irack", {24'd0, ir_ack}, 0);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t3_data", {24'd0, data_out}, 8'h47);
        inta_n = 1'b1; tick();
        chk("t3_idle", {31'd0, ack_busy}, 0);

        // 4: non-specific EOI, fully nested then rotating
        handshake(3'd2, 8'h42);
        handshake(3'd5, 8'h45);
        chk("t4_isr", {24'd0, isr}, 8'h24);
        eoi_nonspec = 1'b1; tick(); eoi_nonspec = 1'b0;
        chk("t4_fn", {24'd0, isr}, 8'h20);
        rotate_on_eoi = 1'b1;
        pulse_spec(3'd4);
        chk("t4_last4", {29'd0, last_serviced}, 4);
        handshake(3'd2, 8'h42);
        chk("t4_isr2", {24'd0, isr}, 8'h24);
        rotating_mode = 1'b1;
        eoi_nonspec = 1'b1; tick(); eoi_nonspec = 1'b0;
        chk("t4_rot", {24'd0, isr}, 8'h04);
        chk("t4_last5", {29'd0, last_serviced}, 5);
        // both strobes: specific wins, non-specific ignored
        eoi_spec = 1'b1; eoi_level = 3'd6; eoi_nonspec = 1'b1; tick();
        eoi_spec = 1'b0; eoi_nonspec = 1'b0;
        chk("t4_both", {24'd0, isr}, 8'h04);
        chk("t4_both_last", {29'd0, last_serviced}, 6);
        rotating_mode = 1'b0; rotate_on_eoi = 1'b0;

        // 5: second INTA never comes -> timeout
        int_flag = 1'b1; priority_id = 3'd6; tick();
        inta_n = 1'b0; tick();
        int_flag = 1'b0; inta_n = 1'b1; tick();
        for (int i = 0; i < 255; i++) tick();
        chk("t5_busy_edge", {31'd0, ack_busy}, 1);
        tick();
        chk("t5_busy", {31'd0, ack_busy}, 0);
        chk("t5_isr", {24'd0, isr}, 8'h44);

        // 6: reset during ACK2
        int_flag = 1'b1; priority_id = 3'd1; tick();
        inta_n = 1'b0; tick();
        int_flag = 1'b0; inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t6_oe_pre", {31'd0, data_oe}, 1);
        reset = 1'b1; tick();
        chk("t6_oe", {31'd0, data_oe}, 0);
        chk("t6_data", {24'd0, data_out}, 0);
        chk("t6_isr", {24'd0, isr}, 0);
        chk("t6_last", {29'd0, last_serviced}, 7);
        chk("t6_busy", {31'd0, ack_busy}, 0);
        chk("t6_int", {31'd0, int_out}, 0);
        inta_n = 1'b1; tick();
        reset = 1'b0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
